// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit words for the instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);

  localparam int             WCW       = $clog2(IMEM_WORDS + 1);
  localparam logic [15:0]    MAX_WORDS = 16'(IMEM_WORDS);
  localparam logic [WCW-1:0] WORD_ONE  = {{(WCW-1){1'b0}}, 1'b1};
  localparam logic [WCW-1:0] WORD_ZERO = {WCW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  state_e         state_q, state_d;
  logic [7:0]     len_lo_q, len_lo_d;
  logic [WCW-1:0] n_q, n_d;
  logic [WCW-1:0] word_idx_q, word_idx_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]    word_q, word_d;
  logic           rx_ready_q, rx_ready_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           cpu_rst_n_q, cpu_rst_n_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           hs_s;
  logic [15:0]    len_s;
  logic [31:0]    asm_s;
  logic [31:0]    offset_s;
  logic           last_word_s;

  assign hs_s        = rx_valid & rx_ready_q;
  assign len_s       = {rx_data, len_lo_q};
  // Bytes shift in from the top so the first byte of a word ends up in [7:0].
  assign asm_s       = {rx_data, word_q[31:8]};
  assign offset_s    = {{(30-WCW){1'b0}}, word_idx_q, 2'b00};
  assign last_word_s = ((word_idx_q + WORD_ONE) == n_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Running XOR of every length and data byte accepted.
  always_comb begin
    csum_d = csum_q;
    if (hs_s && (state_q == ST_LEN_LO || state_q == ST_LEN_HI || state_q == ST_DATA)) begin
      csum_d = csum_next(csum_q, rx_data);
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (hs_s) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end else begin
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (hs_s) begin
          if (len_s == 16'd0) begin
            state_d = ST_AFTER_DATA;
          end else if (len_s > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d    = ST_DATA;
            n_d        = len_s[WCW-1:0];
            word_idx_d = WORD_ZERO;
            byte_cnt_d = 2'd0;
          end
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          word_d     = asm_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + offset_s;
            wdata_d    = asm_s;
            word_idx_d = word_idx_q + WORD_ONE;
            state_d    = last_word_s ? ST_AFTER_DATA : ST_DATA;
          end else begin
            state_d    = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (hs_s) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    // No byte is taken in the cycle that drives a memory write.
    rx_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                  (state_d == ST_CSUM) ||
`endif
                  ((state_d == ST_DATA) && !we_d);
    cpu_rst_n_d = (state_q == ST_DONE);
    done_d      = (state_q == ST_DONE);
    err_d       = (state_q == ST_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= 8'h00;
      n_q         <= WORD_ZERO;
      word_idx_q  <= WORD_ZERO;
      byte_cnt_q  <= 2'd0;
      word_q      <= 32'h0;
      rx_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'h0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset_n = cpu_rst_n_q;
  assign load_done   = done_q;
  assign load_error  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and
// matched when imem_we pulses. Honours IMEM_LOADER_CHECKSUM_EN for the trailing byte.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  int          wr0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_w;
  logic [31:0] img_w[0:63];

  imem_loader #(.IMEM_WORDS(64), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n && imem_we) begin
      wr_cnt++;
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("we_rdy_low", {63'd0, rx_ready}, 64'd0);
`endif
      check("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        check("wr_addr", {32'd0, imem_addr}, {32'd0, exp_w[63:32]});
        check("wr_data", {32'd0, imem_wdata}, {32'd0, exp_w[31:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rx_ready) begin
        @(posedge clock);
        acc = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
    #1 rx_valid = 1'b0;
    check("hs_ok", {63'd0, acc}, 64'd1);
  endtask

  task automatic load_image(input int n, input int gap, input logic [7:0] flip);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] a;
    logic [15:0] n16;
    n16 = 16'(n);
    x = n16[7:0] ^ n16[15:8];
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int w = 0; w < n; w++) begin
      a = 32'(w * 4);
      sb_q.push_back({a, img_w[w]});
      for (int k = 0; k < 4; k++) begin
        b = img_w[w][8*k +: 8];
        x = x ^ b;
        send_byte(b);
        repeat (gap) @(negedge clock);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x ^ flip);
`else
    b = flip;
`endif
  endtask

  task automatic wait_flag(input string tag, input bit want_done);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = want_done ? load_done : load_error;
    end
    check(tag, {63'd0, seen}, 64'd1);
    check({tag, "_cpu"}, {63'd0, cpu_reset_n}, {63'd0, want_done});
    check({tag, "_excl"}, {63'd0, load_done & load_error}, 64'd0);
    check({tag, "_rdy"}, {63'd0, rx_ready}, 64'd0);
  endtask

  task automatic do_reset();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    #2 reset_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("rst_flags", {59'd0, rx_ready, imem_we, cpu_reset_n, load_done, load_error}, 64'd0);
    check("rst_addr", {32'd0, imem_addr}, 64'd0);
    check("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    repeat (2) @(negedge clock);
    check("rst_hold", {59'd0, rx_ready, imem_we, cpu_reset_n, load_done, load_error}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rdy_lenlo", {63'd0, rx_ready}, 64'd1);
  endtask

  initial begin
    do_reset();

    // 1: two-word image, done flag timing
    wr0 = wr_cnt;
    img_w[0] = 32'h00000013;
    img_w[1] = 32'h00100093;
    load_image(2, 0, 8'h00);
    @(negedge clock);
    check("t1_done_early", {63'd0, load_done}, 64'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_we_last", {63'd0, imem_we}, 64'd1);
`endif
    @(negedge clock);
    check("t1_done", {63'd0, load_done}, 64'd1);
    check("t1_cpu", {63'd0, cpu_reset_n}, 64'd1);
    check("t1_wrs", 64'(wr_cnt - wr0), 64'd2);

    // 2: empty image
    do_reset();
    wr0 = wr_cnt;
    load_image(0, 0, 8'h00);
    wait_flag("t2_done", 1'b1);
    check("t2_nowr", 64'(wr_cnt - wr0), 64'd0);

    // 3: oversize image (N=65) -> error, nothing accepted afterwards
    do_reset();
    wr0 = wr_cnt;
    send_byte(8'h41);
    send_byte(8'h00);
    wait_flag("t3_err", 1'b0);
    @(negedge clock);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    repeat (10) @(negedge clock);
    rx_valid = 1'b0;
    check("t3_rdy", {63'd0, rx_ready}, 64'd0);
    check("t3_err_hold", {62'd0, load_error, load_done}, 64'd2);
    check("t3_nowr", 64'(wr_cnt - wr0), 64'd0);

    // 4: one word with rx_valid on alternate cycles
    do_reset();
    wr0 = wr_cnt;
    img_w[0] = 32'hCAFEF00D;
    load_image(1, 1, 8'h00);
    wait_flag("t4_done", 1'b1);
    check("t4_wrs", 64'(wr_cnt - wr0), 64'd1);

    // 5: reset in the middle of the first word, then a clean reload
    do_reset();
    wr0 = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset();
    img_w[0] = 32'h89ABCDEF;
    load_image(1, 0, 8'h00);
    wait_flag("t5_done", 1'b1);
    check("t5_wrs", 64'(wr_cnt - wr0), 64'd1);

    // Full-size image of IMEM_WORDS words
    do_reset();
    wr0 = wr_cnt;
    for (int i = 0; i < 64; i++) img_w[i] = $urandom;
    load_image(64, 0, 8'h00);
    wait_flag("tmax_done", 1'b1);
    check("tmax_wrs", 64'(wr_cnt - wr0), 64'd64);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: good checksum (0x01) then bad checksum (0x00)
    do_reset();
    img_w[0] = 32'hDDCCBBAA;
    load_image(1, 0, 8'h00);
    wait_flag("t6_good", 1'b1);
    do_reset();
    wr0 = wr_cnt;
    load_image(1, 0, 8'h01);
    wait_flag("t6_bad", 1'b0);
    check("t6_wrs", 64'(wr_cnt - wr0), 64'd1);
`endif

    repeat (2) @(negedge clock);
    check("sb_final", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
